// File: rtl/ring_meas_sequencer.sv
// Ring-oscillator measurement sequencer: settle/clear/gate/drain one ring at a time, then sample the grey count.
// Define RING_MEAS_CONTINUOUS_EN to keep re-running the latched sweep until reset or a start in DONE.
module ring_meas_sequencer #(
    parameter int NRINGS       = 6,
    parameter int SEL_W        = 3,
    parameter int CNT_W        = 16,
    parameter int SETTLE_CYC   = 16,
    parameter int CLEAR_CYC    = 4,
    parameter int GATE_CYC     = 1024,
    parameter int DRAIN_CYC    = 4,
    parameter int SAMPLE_TRIES = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [NRINGS-1:0] i_ring_mask,
    input  logic [CNT_W-1:0]  i_gray_cnt,
    output logic [NRINGS-1:0] o_ring_en,
    output logic [SEL_W-1:0]  o_ring_sel,
    output logic              o_cnt_clr,
    output logic              o_cnt_run,
    output logic              o_busy,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [SEL_W-1:0]  o_res_ring,
    output logic [CNT_W-1:0]  o_res_count,
    output logic              o_res_err,
    output logic              o_done
);

    localparam int MAX_A   = (SETTLE_CYC > CLEAR_CYC) ? SETTLE_CYC : CLEAR_CYC;
    localparam int MAX_B   = (GATE_CYC > DRAIN_CYC) ? GATE_CYC : DRAIN_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;
    localparam int TRY_W   = $clog2(SAMPLE_TRIES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CLEAR,
        S_GATE,
        S_DRAIN,
        S_SAMPLE,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t            state;
    logic [NRINGS-1:0] mask;
    logic [NRINGS-1:0] rem_mask;
    logic [TMR_W-1:0]  timer;
    logic [TRY_W-1:0]  tries;
    logic [CNT_W-1:0]  sync1;
    logic [CNT_W-1:0]  sync2;
    logic [CNT_W-1:0]  prev;
`ifdef RING_MEAS_CONTINUOUS_EN
    logic [NRINGS-1:0] orig_mask;
`endif

    function automatic logic [SEL_W-1:0] lowest_set(input logic [NRINGS-1:0] m);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NRINGS - 1; i >= 0; i--) begin
            if (m[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [NRINGS-1:0] onehot(input logic [SEL_W-1:0] s);
        return NRINGS'(1) << s;
    endfunction

    function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
        logic [CNT_W-1:0] b;
        b[CNT_W-1] = g[CNT_W-1];
        for (int i = CNT_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign rem_mask = mask & ~o_ring_en;

    // The grey count comes from another clock domain; prev holds the previous synced value for the stability compare.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= i_gray_cnt;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            mask        <= '0;
            timer       <= '0;
            tries       <= '0;
            o_ring_en   <= '0;
            o_ring_sel  <= '0;
            o_cnt_clr   <= 1'b0;
            o_cnt_run   <= 1'b0;
            o_busy      <= 1'b0;
            o_res_valid <= 1'b0;
            o_res_ring  <= '0;
            o_res_count <= '0;
            o_res_err   <= 1'b0;
            o_done      <= 1'b0;
`ifdef RING_MEAS_CONTINUOUS_EN
            orig_mask   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    o_ring_en <= '0;
                    if (i_start) begin
                        mask <= i_ring_mask;
`ifdef RING_MEAS_CONTINUOUS_EN
                        orig_mask <= i_ring_mask;
`endif
                        if (i_ring_mask == '0) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state      <= S_SETTLE;
                            o_ring_sel <= lowest_set(i_ring_mask);
                            o_ring_en  <= onehot(lowest_set(i_ring_mask));
                            o_busy     <= 1'b1;
                            timer      <= TMR_W'(SETTLE_CYC - 1);
                        end
                    end
                end
                S_SETTLE: begin
                    if (timer == '0) begin
                        state     <= S_CLEAR;
                        o_cnt_clr <= 1'b1;
                        timer     <= TMR_W'(CLEAR_CYC - 1);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (timer == '0) begin
                        state     <= S_GATE;
                        o_cnt_clr <= 1'b0;
                        o_cnt_run <= 1'b1;
                        timer     <= TMR_W'(GATE_CYC - 1);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_GATE: begin
                    if (timer == '0) begin
                        state     <= S_DRAIN;
                        o_cnt_run <= 1'b0;
                        timer     <= TMR_W'(DRAIN_CYC - 1);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (timer == '0) begin
                        state <= S_SAMPLE;
                        tries <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                // A count that reads the same twice in a row is frozen; give up after the try budget.
                S_SAMPLE: begin
                    if (sync2 == prev || tries == TRY_W'(SAMPLE_TRIES - 1)) begin
                        state       <= S_OUTPUT;
                        o_res_valid <= 1'b1;
                        o_res_ring  <= o_ring_sel;
                        o_res_count <= gray2bin(sync2);
                        o_res_err   <= (sync2 != prev);
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (i_res_ready) begin
                        o_res_valid <= 1'b0;
                        mask        <= rem_mask;
                        if (rem_mask == '0) begin
                            state     <= S_DONE;
                            o_ring_en <= '0;
                            o_busy    <= 1'b0;
                            o_done    <= 1'b1;
                        end else begin
                            state      <= S_SETTLE;
                            o_ring_sel <= lowest_set(rem_mask);
                            o_ring_en  <= onehot(lowest_set(rem_mask));
                            timer      <= TMR_W'(SETTLE_CYC - 1);
                        end
                    end
                end
                S_DONE: begin
                    o_done    <= 1'b0;
                    o_ring_en <= '0;
                    o_busy    <= 1'b0;
                    state     <= S_IDLE;
`ifdef RING_MEAS_CONTINUOUS_EN
                    if (!i_start && orig_mask != '0) begin
                        state      <= S_SETTLE;
                        mask       <= orig_mask;
                        o_ring_sel <= lowest_set(orig_mask);
                        o_ring_en  <= onehot(lowest_set(orig_mask));
                        o_busy     <= 1'b1;
                        timer      <= TMR_W'(SETTLE_CYC - 1);
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
